// File: rtl/cd_host_if_if.sv
// A-bus and CD-core signal bundle for the CD-block host interface.
// The slave view is the host interface block; the master view is the SCU/CD-core side.
interface cd_host_if_if;
  logic [25:1] AA;
  logic        ACS2_N;
  logic        ARD_N;
  logic        AWRL_N;
  logic        AWRU_N;
  logic [15:0] ADO;
  logic [15:0] ADI;
  logic        AIRQ_N;
  logic        CMD_VALID;
  logic [63:0] CMD;
  logic        CMD_ACK;
  logic        ST_VALID;
  logic [63:0] ST;
  logic [15:0] ST_HIRQ;
  logic        DATA_WE;
  logic [15:0] DATA_D;
  logic        DATA_FULL;

  modport slave (
    input  AA, ACS2_N, ARD_N, AWRL_N, AWRU_N, ADO,
    input  CMD_ACK, ST_VALID, ST, ST_HIRQ, DATA_WE, DATA_D,
    output ADI, AIRQ_N, CMD_VALID, CMD, DATA_FULL
  );

  modport master (
    output AA, ACS2_N, ARD_N, AWRL_N, AWRU_N, ADO,
    output CMD_ACK, ST_VALID, ST, ST_HIRQ, DATA_WE, DATA_D,
    input  ADI, AIRQ_N, CMD_VALID, CMD, DATA_FULL
  );
endinterface

// File: rtl/cd_host_if.sv
// CD-block host interface: HIRQ/HIRQMASK/CR1-CR4 registers and the DTR FIFO
// on the SCU A-bus CS2 window, bridging host commands and CD-core status.
module cd_host_if #(
  parameter int FIFO_AW = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CE_R,
  cd_host_if_if.slave  bus
);

  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(2 ** FIFO_AW);

  logic [15:0] offset;
  logic        sel;
  logic        wr_n;
  logic        wr_q;
  logic        rd_q;
  logic        rd_sel0_q;
  logic        wr_ev;
  logic        pop_req;
  logic        wr_hirq, wr_mask, wr_cr1, wr_cr2, wr_cr3, wr_cr4;

  logic [15:0] hirq;
  logic [15:0] hirq_next;
  logic [15:0] hirq_mask;
  logic [15:0] st_cr1, st_cr2, st_cr3, st_cr4;
  logic [63:0] cmd_q;
  logic        cmd_valid_q;
  logic        airq_n_q;

  logic [15:0]        fifo_mem [2 ** FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               push;
  logic               pop;
  logic [15:0]        adi;

  assign sel    = !bus.ACS2_N && (bus.AA[25:16] == 10'h189);
  assign offset = {bus.AA[15:1], 1'b0};
  assign wr_n   = bus.AWRL_N & bus.AWRU_N;

  // Strobes are edge-detected against the previous CE_R sample so a held strobe acts once.
  assign wr_ev   = CE_R && sel && !wr_n && wr_q;
  assign pop_req = CE_R && bus.ARD_N && !rd_q && rd_sel0_q;

  assign wr_hirq = wr_ev && (offset == 16'h0008);
  assign wr_mask = wr_ev && (offset == 16'h000C);
  assign wr_cr1  = wr_ev && (offset == 16'h0018);
  assign wr_cr2  = wr_ev && (offset == 16'h001C);
  assign wr_cr3  = wr_ev && (offset == 16'h0020);
  assign wr_cr4  = wr_ev && (offset == 16'h0024);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_q      <= 1'b1;
      rd_q      <= 1'b1;
      rd_sel0_q <= 1'b0;
    end else if (CE_R) begin
      wr_q      <= wr_n;
      rd_q      <= bus.ARD_N;
      rd_sel0_q <= sel && (offset == 16'h0000);
    end
  end

  // Status pulses and core set-bits are applied last so sets win over host clears.
  always_comb begin
    hirq_next = hirq;
    if (wr_hirq)
      hirq_next = hirq & bus.ADO;
    if (wr_cr4)
      hirq_next[0] = 1'b0;
    if (bus.ST_VALID)
      hirq_next[0] = 1'b1;
    hirq_next = hirq_next | bus.ST_HIRQ;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hirq      <= 16'h0001;
      hirq_mask <= 16'hFFFF;
      airq_n_q  <= 1'b1;
    end else if (CE_R) begin
      hirq     <= hirq_next;
      airq_n_q <= !(|(hirq & hirq_mask));
      if (wr_mask)
        hirq_mask <= bus.ADO;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_cr1 <= 16'h0043;
      st_cr2 <= 16'h4442;
      st_cr3 <= 16'h4C4F;
      st_cr4 <= 16'h434B;
    end else if (CE_R && bus.ST_VALID) begin
      st_cr1 <= bus.ST[63:48];
      st_cr2 <= bus.ST[47:32];
      st_cr3 <= bus.ST[31:16];
      st_cr4 <= bus.ST[15:0];
    end
  end

  // A CR4 write takes priority over an acknowledge in the same cycle (latest command wins).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmd_q       <= 64'h0;
      cmd_valid_q <= 1'b0;
    end else if (CE_R) begin
      if (wr_cr1) cmd_q[63:48] <= bus.ADO;
      if (wr_cr2) cmd_q[47:32] <= bus.ADO;
      if (wr_cr3) cmd_q[31:16] <= bus.ADO;
      if (wr_cr4) cmd_q[15:0]  <= bus.ADO;
      if (wr_cr4)
        cmd_valid_q <= 1'b1;
      else if (bus.CMD_ACK)
        cmd_valid_q <= 1'b0;
    end
  end

  assign full = (count == DEPTH);
  assign push = CE_R && bus.DATA_WE && !full;
  assign pop  = pop_req && (count != '0);

  always_ff @(posedge CLK) begin
    if (push)
      fifo_mem[wr_ptr] <= bus.DATA_D;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    adi = 16'h0000;
    if (sel) begin
      case (offset)
        16'h0000: adi = (count == '0) ? 16'h0000 : fifo_mem[rd_ptr];
        16'h0008: adi = hirq;
        16'h000C: adi = hirq_mask;
        16'h0018: adi = st_cr1;
        16'h001C: adi = st_cr2;
        16'h0020: adi = st_cr3;
        16'h0024: adi = st_cr4;
        default:  adi = 16'h0000;
      endcase
    end
  end

  assign bus.ADI       = adi;
  assign bus.AIRQ_N    = airq_n_q;
  assign bus.CMD_VALID = cmd_valid_q;
  assign bus.CMD       = cmd_q;
  assign bus.DATA_FULL = full;

endmodule

// File: tb/tb_cd_host_if.sv
// Directed self-checking bench for cd_host_if: registers, command handshake,
// status path, DTR FIFO ordering/boundaries and asynchronous reset.
module tb_cd_host_if;

  logic CLK;
  logic RST_N;
  logic CE_R;
  int   checks;
  int   errors;
  logic [15:0] rdata;

  cd_host_if_if bus ();

  cd_host_if #(.FIFO_AW(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE_R  (CE_R),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setAddr(input logic [15:0] off);
    bus.AA = {10'h189, off[15:1]};
  endtask

  task automatic busWrite(input logic [15:0] off, input logic [15:0] data);
    setAddr(off);
    bus.ADO    = data;
    bus.ACS2_N = 1'b0;
    bus.AWRL_N = 1'b0;
    bus.AWRU_N = 1'b0;
    tick();
    bus.AWRL_N = 1'b1;
    bus.AWRU_N = 1'b1;
    bus.ACS2_N = 1'b1;
    tick();
  endtask

  task automatic busRead(input logic [15:0] off, output logic [15:0] data);
    setAddr(off);
    bus.ACS2_N = 1'b0;
    bus.ARD_N  = 1'b0;
    tick();
    data = bus.ADI;
    bus.ARD_N = 1'b1;
    tick();
    bus.ACS2_N = 1'b1;
  endtask

  // One-cycle pulse of CD-core status / interrupt inputs.
  task automatic applyStimulus(input logic st_valid, input logic [63:0] st,
                               input logic [15:0] st_hirq, input logic ack);
    bus.ST_VALID = st_valid;
    bus.ST       = st;
    bus.ST_HIRQ  = st_hirq;
    bus.CMD_ACK  = ack;
    tick();
    bus.ST_VALID = 1'b0;
    bus.ST_HIRQ  = 16'h0000;
    bus.CMD_ACK  = 1'b0;
  endtask

  task automatic pushWord(input logic [15:0] d);
    bus.DATA_WE = 1'b1;
    bus.DATA_D  = d;
    tick();
    bus.DATA_WE = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST_N = 1'b0;
    CE_R  = 1'b1;
    bus.AA = '0;
    bus.ACS2_N = 1'b1;
    bus.ARD_N  = 1'b1;
    bus.AWRL_N = 1'b1;
    bus.AWRU_N = 1'b1;
    bus.ADO = '0;
    bus.CMD_ACK = 1'b0;
    bus.ST_VALID = 1'b0;
    bus.ST = '0;
    bus.ST_HIRQ = '0;
    bus.DATA_WE = 1'b0;
    bus.DATA_D = '0;
    $display("[TB] start");
    tick();
    tick();

    checkOutput("rst_airq_n",    {63'b0, bus.AIRQ_N},    64'd1);
    checkOutput("rst_cmd_valid", {63'b0, bus.CMD_VALID}, 64'd0);
    checkOutput("rst_cmd",       bus.CMD,                64'd0);
    checkOutput("rst_full",      {63'b0, bus.DATA_FULL}, 64'd0);
    checkOutput("rst_adi",       {48'b0, bus.ADI},       64'd0);

    RST_N = 1'b1;
    tick();
    tick();
    checkOutput("airq_after_rst", {63'b0, bus.AIRQ_N}, 64'd0);

    busRead(16'h0018, rdata); checkOutput("rst_cr1", {48'b0, rdata}, 64'h0043);
    busRead(16'h001C, rdata); checkOutput("rst_cr2", {48'b0, rdata}, 64'h4442);
    busRead(16'h0020, rdata); checkOutput("rst_cr3", {48'b0, rdata}, 64'h4C4F);
    busRead(16'h0024, rdata); checkOutput("rst_cr4", {48'b0, rdata}, 64'h434B);
    busRead(16'h0008, rdata); checkOutput("rst_hirq", {48'b0, rdata}, 64'h0001);
    busRead(16'h000C, rdata); checkOutput("rst_mask", {48'b0, rdata}, 64'hFFFF);

    busWrite(16'h000C, 16'h0000);
    busWrite(16'h0008, 16'h0000);
    tick();
    checkOutput("masked_airq", {63'b0, bus.AIRQ_N}, 64'd1);

    busWrite(16'h000C, 16'h0001);
    applyStimulus(1'b1, 64'h1111_2222_3333_4444, 16'h0000, 1'b0);
    checkOutput("airq_lat_n", {63'b0, bus.AIRQ_N}, 64'd1);
    tick();
    checkOutput("airq_lat_n1", {63'b0, bus.AIRQ_N}, 64'd0);
    busRead(16'h0008, rdata); checkOutput("st_hirq0", {48'b0, rdata}, 64'h0001);
    busRead(16'h0018, rdata); checkOutput("st_cr1", {48'b0, rdata}, 64'h1111);
    busRead(16'h0024, rdata); checkOutput("st_cr4", {48'b0, rdata}, 64'h4444);

    busWrite(16'h0010, 16'hBEEF);
    busRead(16'h0010, rdata); checkOutput("unmapped_rd", {48'b0, rdata}, 64'h0000);
    bus.AA = {10'h188, 15'h000C};
    bus.ACS2_N = 1'b0;
    #1;
    checkOutput("nosel_adi", {48'b0, bus.ADI}, 64'h0000);
    bus.ACS2_N = 1'b1;

    busWrite(16'h0018, 16'h0100);
    busWrite(16'h001C, 16'h0000);
    busWrite(16'h0020, 16'h0000);
    busWrite(16'h0024, 16'h0001);
    checkOutput("cmd_valid", {63'b0, bus.CMD_VALID}, 64'd1);
    checkOutput("cmd_word",  bus.CMD, 64'h0100_0000_0000_0001);
    busRead(16'h0008, rdata); checkOutput("cmd_clr_hirq0", {48'b0, rdata}, 64'h0000);
    applyStimulus(1'b0, 64'h0, 16'h0000, 1'b1);
    checkOutput("ack_clears", {63'b0, bus.CMD_VALID}, 64'd0);

    busWrite(16'h0018, 16'h0200);
    busWrite(16'h0024, 16'h0002);
    busWrite(16'h0024, 16'h0003);
    checkOutput("latest_cmd", bus.CMD, 64'h0200_0000_0000_0003);
    checkOutput("latest_valid", {63'b0, bus.CMD_VALID}, 64'd1);
    applyStimulus(1'b0, 64'h0, 16'h0000, 1'b1);
    checkOutput("single_ack", {63'b0, bus.CMD_VALID}, 64'd0);

    // CR4 write and acknowledge on the same edge: new command stays pending.
    setAddr(16'h0024);
    bus.ADO = 16'h0004;
    bus.ACS2_N = 1'b0;
    bus.AWRL_N = 1'b0;
    bus.CMD_ACK = 1'b1;
    tick();
    bus.CMD_ACK = 1'b0;
    bus.AWRL_N = 1'b1;
    bus.ACS2_N = 1'b1;
    tick();
    checkOutput("ack_wr_valid", {63'b0, bus.CMD_VALID}, 64'd1);
    checkOutput("ack_wr_cmd",   bus.CMD, 64'h0200_0000_0000_0004);
    applyStimulus(1'b0, 64'h0, 16'h0000, 1'b1);

    for (int i = 0; i < 16; i++) pushWord(16'(i));
    checkOutput("fifo_full", {63'b0, bus.DATA_FULL}, 64'd1);
    pushWord(16'hDEAD);
    checkOutput("fifo_full_drop", {63'b0, bus.DATA_FULL}, 64'd1);
    for (int i = 0; i < 16; i++) begin
      busRead(16'h0000, rdata);
      checkOutput($sformatf("fifo_rd%0d", i), {48'b0, rdata}, 64'(i));
    end
    checkOutput("fifo_not_full", {63'b0, bus.DATA_FULL}, 64'd0);
    busRead(16'h0000, rdata); checkOutput("fifo_empty_rd", {48'b0, rdata}, 64'h0000);

    for (int i = 0; i < 5; i++) pushWord(16'h00A0 + 16'(i));
    setAddr(16'h0000);
    bus.ACS2_N = 1'b0;
    bus.ARD_N  = 1'b0;
    tick();
    checkOutput("pp_head", {48'b0, bus.ADI}, 64'h00A0);
    bus.ARD_N   = 1'b1;
    bus.DATA_WE = 1'b1;
    bus.DATA_D  = 16'h00A5;
    tick();
    bus.DATA_WE = 1'b0;
    bus.ACS2_N  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      busRead(16'h0000, rdata);
      checkOutput($sformatf("pp_rd%0d", i), {48'b0, rdata}, 64'h00A0 + 64'(i));
    end
    busRead(16'h0000, rdata); checkOutput("pp_empty", {48'b0, rdata}, 64'h0000);

    applyStimulus(1'b0, 64'h0, 16'h00F0, 1'b0);
    setAddr(16'h0008);
    bus.ADO = 16'h0030;
    bus.ACS2_N = 1'b0;
    bus.AWRL_N = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.ST_HIRQ = 16'h0040;
    tick();
    bus.ST_HIRQ = 16'h0000;
    for (int i = 0; i < 5; i++) tick();
    bus.AWRL_N = 1'b1;
    bus.ACS2_N = 1'b1;
    tick();
    busRead(16'h0008, rdata); checkOutput("held_wr_once", {48'b0, rdata}, 64'h0070);

    CE_R = 1'b0;
    bus.ST_HIRQ = 16'h0100;
    tick();
    bus.ST_HIRQ = 16'h0000;
    CE_R = 1'b1;
    busRead(16'h0008, rdata); checkOutput("ce_gate", {48'b0, rdata}, 64'h0070);

    bus.ST_HIRQ = 16'h0010;
    busWrite(16'h0008, 16'h0000);
    bus.ST_HIRQ = 16'h0000;
    busRead(16'h0008, rdata); checkOutput("set_wins", {48'b0, rdata}, 64'h0010);

    busWrite(16'h000C, 16'hFFFF);
    busWrite(16'h0024, 16'h0009);
    for (int i = 0; i < 3; i++) pushWord(16'h0050 + 16'(i));
    tick();
    checkOutput("pre_rst_airq",  {63'b0, bus.AIRQ_N},    64'd0);
    checkOutput("pre_rst_valid", {63'b0, bus.CMD_VALID}, 64'd1);
    setAddr(16'h0000);
    bus.ACS2_N = 1'b0;
    #1;
    checkOutput("pre_rst_head", {48'b0, bus.ADI}, 64'h0050);
    RST_N = 1'b0;
    #1;
    checkOutput("arst_valid", {63'b0, bus.CMD_VALID}, 64'd0);
    checkOutput("arst_airq",  {63'b0, bus.AIRQ_N},    64'd1);
    checkOutput("arst_fifo",  {48'b0, bus.ADI},       64'h0000);
    bus.ACS2_N = 1'b1;
    tick();
    RST_N = 1'b1;
    tick();
    busRead(16'h0000, rdata); checkOutput("post_rst_fifo", {48'b0, rdata}, 64'h0000);
    busRead(16'h0008, rdata); checkOutput("post_rst_hirq", {48'b0, rdata}, 64'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cd_host_if.md
# cd_host_if

CD-block host interface on the SCU A-bus CS2 window at 0x25890000. It provides the HIRQ, HIRQMASK and CR1–CR4 registers and a 16-bit data-transfer FIFO (DTR) to the SH-2 side. It passes host commands to, and returns status from, the CD controller core. Its A-bus outputs feed the SCU's ADI/AIRQ_N inputs directly.

## Interface
- FIFO_AW, 4, log2 of DTR FIFO depth (16 words)
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- CE_R  in  1  clock enable; all state advances only on CLK edges with CE_R=1
- AA  in  25  A-bus address [25:1]
- ACS2_N  in  1  A-bus CS2, active-low
- ARD_N  in  1  A-bus read strobe, active-low
- AWRL_N, AWRU_N  in  1 each  A-bus write strobes, active-low
- ADO  in  16  write data from SCU
- ADI  out  16  read data to SCU (combinational)
- AIRQ_N  out  1  interrupt to SCU, active-low, registered
- CMD_VALID  out  1  command pending to CD core
- CMD  out  64  {CR1,CR2,CR3,CR4} command words
- CMD_ACK  in  1  CD core accepts command (1 CE_R pulse)
- ST_VALID  in  1  status word valid (1 CE_R pulse)
- ST  in  64  {CR1,CR2,CR3,CR4} status words
- ST_HIRQ  in  16  HIRQ bits to set; sampled with ST_VALID and on every CE_R
- DATA_WE  in  1  CD core pushes DATA_D into FIFO
- DATA_D  in  16  FIFO write data
- DATA_FULL  out  1  FIFO full

## Operation
- Select: SEL = !ACS2_N && AA[25:16]==10'h189. Offset = {AA[15:1],0}.
- Write event: falling edge of (AWRL_N & AWRU_N) with SEL, detected against the previous CE_R sample.
- Read-done event: rising edge of ARD_N with SEL at the previous sample.
- Registers and reset values:
  - HIRQ = 0x0001 (CMOK set).
  - HIRQMASK = 0xFFFF.
  - Status CR1..CR4 = 0x0043, 0x4442, 0x4C4F, 0x434B.
  - Command CMD words = 0.
- Writes:
  - 0x08 HIRQ ← (HIRQ & ADO) | ST_HIRQ. Set bits win over clears in the same cycle.
  - 0x0C HIRQMASK ← ADO.
  - 0x18/0x1C/0x20 load command words CR1/CR2/CR3.
  - 0x24 loads command word CR4, then sets CMD_VALID=1 and clears HIRQ[0].
  - All other offsets are ignored.
- Reads (ADI): 0x00 FIFO head (0x0000 if empty); 0x08 HIRQ; 0x0C HIRQMASK; 0x18–0x24 status CR1–CR4. ADI = 0 when not SEL or at any other offset.
- Command handshake:
  - CMD_VALID is held until a CE_R cycle with CMD_ACK=1, then cleared.
  - A CR4 write while CMD_VALID=1 replaces CMD and keeps CMD_VALID=1 (latest wins).
  - CMD_ACK in the same cycle as a CR4 write: CMD_VALID stays 1 and holds the new command.
- Status:
  - ST_VALID loads the status CR1–CR4 from ST and sets HIRQ[0].
  - ST_HIRQ bits are ORed into HIRQ on every CE_R.
- FIFO:
  - Circular buffer of 2^FIFO_AW words with an (FIFO_AW+1)-bit count.
  - DATA_WE when full: data dropped, pointers and count unchanged.
  - Read-done at 0x00 pops the head; a pop when empty has no effect.
  - Push and pop in the same cycle: both occur, count unchanged. Pop-when-empty combined with push: push only.
  - Pointers wrap modulo 2^FIFO_AW.
  - DATA_FULL = (count == 2^FIFO_AW).
- AIRQ_N ← !(|(HIRQ & HIRQMASK)), registered from current HIRQ/HIRQMASK.

## Timing
- Output reset values: AIRQ_N=1, CMD_VALID=0, CMD=0, DATA_FULL=0, ADI=0.
- Strobes are level-sampled once per CE_R. A strobe held low across many CE_R cycles acts exactly once.
- CR4 write edge detected at CE_R cycle N → CMD_VALID=1 and HIRQ[0]=0 visible after cycle N.
- HIRQ change at cycle N → AIRQ_N reflects it after cycle N+1.
- ST_VALID at cycle N → status CRs readable after cycle N.
- DTR head is stable for the whole low phase of ARD_N. The pointer advances after the ARD_N rising edge, so the next read sees the next word.
- Asynchronous reset mid-command or mid-transfer clears all state: FIFO empty, pending command lost.

## Test plan
- Reset, read 0x18..0x24 → 0x0043, 0x4442, 0x4C4F, 0x434B. Read 0x08 → 0x0001. AIRQ_N=0 (mask 0xFFFF).
- Write HIRQMASK=0, HIRQ=0x0000 → AIRQ_N=1. Write HIRQMASK=0x0001, pulse ST_VALID with ST=0x1111_2222_3333_4444 → HIRQ[0]=1, AIRQ_N=0 two cycles later, CR1 read = 0x1111.
- Write CR1..CR4 = 0x0100,0,0,0x0001 → CMD_VALID=1, CMD=0x0100_0000_0000_0001, HIRQ[0]=0. CMD_ACK pulse → CMD_VALID=0. Second CR4 write before ACK → CMD updated, single ACK clears.
- Push 16 words 0x0000..0x000F → DATA_FULL=1. 17th push (0xDEAD) dropped. 16 reads return 0x0000..0x000F in order. 17th read returns 0x0000.
- Push and pop on the same CE_R at count=5 → count stays 5 and the read data is correct. Hold AWRL_N low 10 CE_R cycles on HIRQ → exactly one clear applied.
- Same-cycle HIRQ write of 0x0000 with ST_HIRQ=0x0010 → HIRQ=0x0010. Assert RST_N low with CMD_VALID=1 and FIFO count 3 → CMD_VALID=0, FIFO empty, AIRQ_N=1 immediately.
